// File: rtl/miner_pkg.sv
// miner_pkg: shared state type, hash constant and display helpers for the toy miner
package miner_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      REPORT
   } miner_state_t;

   localparam logic [31:0] HASH_K = 32'h6A09E667;

   // Rotate right by a constant amount; n is always in 1..31 at the call sites
   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Hex digit to active-low segments, bit order g..a
   function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/miner_wrapper_uart.sv
// uart_8n1: 8N1 receiver with two-flop input synchroniser plus a transmitter
// that can accept the next byte during the last stop-bit cycle (back-to-back frames).
module uart_8n1
   import miner_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_ready,
   output logic       txd
);

   localparam int BIT_CYC = CLK_HZ / BAUD;
   localparam int CW = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 2;
   localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT
   } rx_state_t;

   rx_state_t rx_state;
   rx_state_t rx_next;
   logic rx_meta;
   logic rx_sync;
   logic rx_prev;
   logic [CW-1:0] rx_cnt;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift;

   logic [9:0] tx_frame;
   logic [3:0] tx_left;
   logic [CW-1:0] tx_cnt;

   // Receiver state register
   always_ff @(posedge clk) begin
      if (!reset) rx_state <= RX_IDLE;
      else rx_state <= rx_next;
   end

   // Receiver next state: a framing error parks in RX_WAIT until the line is high again
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
         RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_cnt == BIT_LAST) rx_next = rx_sync ? RX_IDLE : RX_WAIT;
         RX_WAIT:  if (rx_sync) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   // Receiver datapath: synchroniser, mid-bit timing and LSB-first shifting
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_meta  <= rxd;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_valid <= 1'b0;
         if (rx_state == RX_IDLE || rx_state == RX_WAIT) begin
            rx_cnt <= '0;
            rx_bit <= '0;
         end else if ((rx_state == RX_START && rx_cnt == HALF_LAST) || rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
         end else begin
            rx_cnt <= rx_cnt + 1'b1;
         end
         if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
         end
         if (rx_state == RX_STOP && rx_cnt == BIT_LAST && rx_sync) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
         end
      end
   end

   assign tx_ready = (tx_left == 4'd0) || (tx_left == 4'd1 && tx_cnt == BIT_LAST);
   assign txd = (tx_left == 4'd0) ? 1'b1 : tx_frame[0];

   // Transmitter: shift out start, 8 data bits LSB first, stop
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_frame <= '1;
         tx_left  <= '0;
         tx_cnt   <= '0;
      end else if (tx_start && tx_ready) begin
         tx_frame <= {1'b1, tx_data, 1'b0};
         tx_left  <= 4'd10;
         tx_cnt   <= '0;
      end else if (tx_left != 4'd0) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_frame <= {1'b1, tx_frame[9:1]};
            tx_left  <= tx_left - 4'd1;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/miner_wrapper.sv
// miner_wrapper: board-level toy proof-of-work miner. Loads a seed over UART,
// tries one nonce per cycle, reports the first hit over UART and shows state on
// an 8-digit multiplexed seven-segment display.
module miner_wrapper
   import miner_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int DIFF_BITS    = 16,
   parameter int REFRESH_BITS = 17
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] ca,
   output logic [7:0] an,
   output logic       txd,
   input  logic       rxd,
   input  logic [3:0] display_toggle,
   output logic       hashLed
);

   miner_state_t state;
   miner_state_t state_next;
   logic [31:0] seed;
   logic [31:0] nonce;
   logic [31:0] found;
   logic [31:0] hash_count;
   logic [23:0] seed_shift;
   logic [1:0] byte_cnt;
   logic [1:0] tx_idx;
   logic [31:0] hash_x;
   logic [31:0] hash_h;
   logic hit;
   logic job_done;
   logic [7:0] rx_data;
   logic rx_valid;
   logic tx_ready;
   logic tx_start;
   logic [7:0] tx_data;

   logic [REFRESH_BITS-1:0] refresh_cnt;
   logic [2:0] digit_idx;
   logic [2:0] digit_step;
   logic [31:0] disp_value;
   logic [3:0] disp_nibble;

   uart_8n1 #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD)
   ) uart (
      .clk     (clk),
      .reset   (reset),
      .rxd     (rxd),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .tx_data (tx_data),
      .tx_start(tx_start),
      .tx_ready(tx_ready),
      .txd     (txd)
   );

   assign job_done = rx_valid && (byte_cnt == 2'd3);

   // Toy hash of the current candidate and the leading-zero hit test
   always_comb begin
      hash_x = seed ^ nonce;
      hash_h = (hash_x ^ rotr(hash_x, 2) ^ rotr(hash_x, 13) ^ rotr(hash_x, 22)) + (hash_x ^ HASH_K);
      hit = (hash_h[31 -: DIFF_BITS] == '0);
   end

   // Result byte being reported, MSB first
   always_comb begin
      case (tx_idx)
         2'd0: tx_data = found[31:24];
         2'd1: tx_data = found[23:16];
         2'd2: tx_data = found[15:8];
         default: tx_data = found[7:0];
      endcase
   end

   // Miner state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else state <= state_next;
   end

   // Miner next state; a freshly completed job overrides whatever was in progress
   always_comb begin
      state_next = state;
      tx_start = 1'b0;
      case (state)
         SEARCH: begin
            if (hit) state_next = REPORT;
            else if (nonce == 32'hFFFF_FFFF) state_next = IDLE;
         end
         REPORT: begin
            tx_start = 1'b1;
            if (tx_ready && tx_idx == 2'd3) state_next = IDLE;
         end
         default: state_next = state;
      endcase
      if (job_done) begin
         state_next = SEARCH;
         tx_start = 1'b0;
      end
   end

   // Job assembly, nonce search, result capture and report byte sequencing
   always_ff @(posedge clk) begin
      if (!reset) begin
         seed       <= '0;
         nonce      <= '0;
         found      <= '0;
         hash_count <= '0;
         seed_shift <= '0;
         byte_cnt   <= '0;
         tx_idx     <= '0;
         hashLed    <= 1'b0;
      end else begin
         if (rx_valid) begin
            byte_cnt   <= byte_cnt + 2'd1;
            seed_shift <= {seed_shift[15:0], rx_data};
         end
         if (job_done) begin
            seed    <= {seed_shift, rx_data};
            nonce   <= '0;
            hashLed <= 1'b0;
            tx_idx  <= '0;
         end else begin
            case (state)
               SEARCH: begin
                  hash_count <= hash_count + 32'd1;
                  if (hit) begin
                     found   <= nonce;
                     hashLed <= 1'b1;
                  end else begin
                     nonce <= nonce + 32'd1;
                  end
               end
               REPORT: if (tx_ready) tx_idx <= tx_idx + 2'd1;
               default: tx_idx <= tx_idx;
            endcase
         end
      end
   end

   // Display source select and the nibble for the digit about to be shown
   always_comb begin
      case (display_toggle)
         4'd0: disp_value = nonce;
         4'd1: disp_value = found;
         4'd2: disp_value = seed;
         4'd3: disp_value = hash_count;
         default: disp_value = 32'h0000_0000;
      endcase
      digit_step = digit_idx + 3'd1;
      disp_nibble = disp_value[{digit_step, 2'b00} +: 4];
   end

   // Digit multiplexing: advance one digit per refresh period, registered drive
   always_ff @(posedge clk) begin
      if (!reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
         an          <= 8'hFF;
         ca          <= 8'hFF;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
         if (&refresh_cnt) begin
            digit_idx <= digit_step;
            an        <= ~(8'd1 << digit_step);
            ca        <= {1'b1, hex_to_seg(disp_nibble)};
         end
      end
   end

endmodule

// File: tb/tb_miner_wrapper.sv
// tb_miner_wrapper: randomized self-checking bench for the toy miner; two
// instances with different difficulty share clock, reset and display select.
module tb_miner_wrapper;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD = 100_000;
   localparam int BIT = CLK_HZ / BAUD;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic rxd4 = 1'b0;
   logic rxd12 = 1'b1;
   logic [3:0] displayToggle = 4'd0;
   logic [7:0] ca4, an4, ca12, an12;
   logic txd4, txd12, hashLed4, hashLed12;

   logic [7:0] txQ4[$];
   logic [7:0] txQ12[$];
   int checks = 0;
   int failures = 0;
   int stopErrors = 0;

   always #5 clk = ~clk;

   miner_wrapper #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DIFF_BITS(4), .REFRESH_BITS(2)) dut4 (
      .clk(clk), .reset(resetN), .ca(ca4), .an(an4), .txd(txd4), .rxd(rxd4),
      .display_toggle(displayToggle), .hashLed(hashLed4));

   miner_wrapper #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DIFF_BITS(12), .REFRESH_BITS(2)) dut12 (
      .clk(clk), .reset(resetN), .ca(ca12), .an(an12), .txd(txd12), .rxd(rxd12),
      .display_toggle(displayToggle), .hashLed(hashLed12));

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference hash built from the textual rule, rotation via a doubled word
   function automatic logic [31:0] rotR(input logic [31:0] v, input int n);
      logic [63:0] d;
      d = {v, v} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] modelHash(input logic [31:0] s, input logic [31:0] n);
      logic [31:0] x;
      x = s ^ n;
      return (x ^ rotR(x, 2) ^ rotR(x, 13) ^ rotR(x, 22)) + (x ^ 32'h6A09E667);
   endfunction

   // First nonce below limit whose hash has diff leading zero bits
   task automatic modelFirstHit(input logic [31:0] s, input int diff, input int limit,
                                output logic [31:0] n, output bit ok);
      ok = 1'b0;
      n = '0;
      for (int i = 0; i < limit && !ok; i++) begin
         if ((modelHash(s, i) >> (32 - diff)) == 32'd0) begin
            ok = 1'b1;
            n = i;
         end
      end
   endtask

   // Active-high gfedcba glyph patterns; the board drives their complement
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[d];
   endfunction

   function automatic logic txLine(input int which);
      return (which == 0) ? txd4 : txd12;
   endfunction

   function automatic int qSize(input int which);
      return (which == 0) ? txQ4.size() : txQ12.size();
   endfunction

   task automatic driveRx(input int which, input logic v);
      if (which == 0) rxd4 = v;
      else rxd12 = v;
   endtask

   // Send one 8N1 byte; stopBit=0 produces a framing error, then the line idles high
   task automatic applyStimulus(input int which, input logic [7:0] b, input logic stopBit);
      @(negedge clk);
      driveRx(which, 1'b0);
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         driveRx(which, b[i]);
         repeat (BIT) @(negedge clk);
      end
      driveRx(which, stopBit);
      repeat (BIT) @(negedge clk);
      driveRx(which, 1'b1);
      repeat (BIT) @(negedge clk);
   endtask

   task automatic sendWord(input int which, input logic [31:0] w);
      for (int k = 3; k >= 0; k--) applyStimulus(which, w[8*k +: 8], 1'b1);
   endtask

   // Continuous UART decoder for one DUT's txd
   task automatic monitorTx(input int which);
      logic [7:0] b;
      logic stopBit;
      forever begin
         @(negedge clk);
         if (resetN && txLine(which) == 1'b0) begin
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = txLine(which);
            end
            repeat (BIT) @(negedge clk);
            stopBit = txLine(which);
            if (which == 0) txQ4.push_back(b);
            else txQ12.push_back(b);
            if (stopBit !== 1'b1) stopErrors++;
         end
      end
   endtask

   initial monitorTx(0);
   initial monitorTx(1);

   // Wait (bounded) for four reported bytes and assemble them MSB first
   task automatic waitTxWord(input int which, input int limit, output logic [31:0] word);
      int c;
      c = 0;
      while (qSize(which) < 4 && c < limit) begin
         @(negedge clk);
         c++;
      end
      checkOutput("tx_word_arrived", 64'(qSize(which) >= 4), 64'd1);
      word = '0;
      if (qSize(which) >= 4) begin
         for (int k = 0; k < 4; k++) begin
            if (which == 0) word = {word[23:0], txQ4.pop_front()};
            else word = {word[23:0], txQ12.pop_front()};
         end
      end
   endtask

   // Watch 'steps' digit advances on dut4 and check anode pattern and glyph
   task automatic checkDisplay(input string tag, input logic [31:0] shown, input int steps);
      logic [7:0] prevAn;
      int prevIdx, idx, zeros, seen;
      prevAn = an4;
      prevIdx = -1;
      seen = 0;
      for (int c = 0; c < 12 * steps && seen < steps; c++) begin
         @(negedge clk);
         if (an4 != prevAn) begin
            idx = 0;
            zeros = 0;
            for (int i = 0; i < 8; i++) begin
               if (!an4[i]) begin
                  zeros++;
                  idx = i;
               end
            end
            checkOutput("an_one_low", 64'(zeros), 64'd1);
            if (prevIdx >= 0) checkOutput("an_advance", 64'(idx), 64'((prevIdx + 1) % 8));
            checkOutput(tag, 64'(ca4), 64'({1'b1, ~glyph(shown[4*idx +: 4])}));
            prevIdx = idx;
            prevAn = an4;
            seen++;
         end
      end
      checkOutput("display_steps", 64'(seen), 64'(steps));
   endtask

   initial begin
      logic [31:0] word, expNonce, seedA, seedB, seedC, jobSeed, hc0;
      logic [7:0] jb [5];
      bit ok;
      int lowCount;

      // Reset behaviour
      repeat (10) @(negedge clk);
      checkOutput("reset_txd", 64'(txd4), 64'd1);
      checkOutput("reset_an", 64'(an4), 64'hFF);
      checkOutput("reset_ca", 64'(ca4), 64'hFF);
      checkOutput("reset_hashled", 64'(hashLed4), 64'd0);
      checkOutput("reset_hashled12", 64'(hashLed12), 64'd0);
      resetN = 1'b1;

      // Constant-low line must not produce a job
      lowCount = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (txd4 == 1'b0) lowCount++;
      end
      checkOutput("lowline_no_tx", 64'(lowCount), 64'd0);
      checkOutput("lowline_hashled", 64'(hashLed4), 64'd0);
      checkOutput("lowline_idle_count", 64'(dut4.hash_count), 64'd0);
      rxd4 = 1'b1;
      repeat (20) @(negedge clk);

      // Seed zero with 4-bit difficulty
      modelFirstHit(32'h0, 4, 5000, expNonce, ok);
      sendWord(0, 32'h0);
      waitTxWord(0, 5000, word);
      checkOutput("seed0_nonce", 64'(word), 64'(expNonce));
      checkOutput("seed0_hashled", 64'(hashLed4), 64'd1);

      // Framing error in the middle of a job: third byte discarded
      for (int i = 0; i < 5; i++) jb[i] = 8'($urandom);
      jobSeed = {jb[0], jb[1], jb[3], jb[4]};
      applyStimulus(0, jb[0], 1'b1);
      applyStimulus(0, jb[1], 1'b1);
      applyStimulus(0, jb[2], 1'b0);
      applyStimulus(0, jb[3], 1'b1);
      repeat (50) @(negedge clk);
      checkOutput("framing_no_job_tx", 64'(txQ4.size()), 64'd0);
      checkOutput("framing_no_job_led", 64'(hashLed4), 64'd1);
      applyStimulus(0, jb[4], 1'b1);
      modelFirstHit(jobSeed, 4, 5000, expNonce, ok);
      waitTxWord(0, 5000, word);
      checkOutput("framing_nonce", 64'(word), 64'(expNonce));

      // Seed 12345678 and display of the seed, then an out-of-range select
      modelFirstHit(32'h12345678, 4, 5000, expNonce, ok);
      sendWord(0, 32'h12345678);
      waitTxWord(0, 5000, word);
      checkOutput("seed1234_nonce", 64'(word), 64'(expNonce));
      displayToggle = 4'd2;
      repeat (40) @(negedge clk);
      checkDisplay("seg_seed", 32'h12345678, 16);
      displayToggle = 4'd9;
      repeat (40) @(negedge clk);
      checkDisplay("seg_blank", 32'h0, 8);

      // dut12: a completed job lights the LED
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         seedC = $urandom;
         modelFirstHit(seedC, 12, 8000, expNonce, ok);
      end
      sendWord(1, seedC);
      waitTxWord(1, 9000, word);
      checkOutput("seedC_nonce", 64'(word), 64'(expNonce));
      checkOutput("seedC_hashled", 64'(hashLed12), 64'd1);

      // dut12: seed A with no hit in the first 1500 nonces keeps searching silently
      ok = 1'b1;
      for (int t = 0; t < 50 && ok; t++) begin
         seedA = $urandom;
         modelFirstHit(seedA, 12, 1500, word, ok);
      end
      sendWord(1, seedA);
      checkOutput("seedA_hashled_cleared", 64'(hashLed12), 64'd0);
      hc0 = dut12.hash_count;
      repeat (200) @(negedge clk);
      checkOutput("seedA_count_step", 64'(dut12.hash_count - hc0), 64'd200);
      checkOutput("seedA_no_tx", 64'(txQ12.size()), 64'd0);
      checkOutput("seedA_hashled", 64'(hashLed12), 64'd0);

      // dut12: seed B arrives mid-search and restarts from nonce 0
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         seedB = $urandom;
         modelFirstHit(seedB, 12, 8000, expNonce, ok);
      end
      sendWord(1, seedB);
      waitTxWord(1, 9000, word);
      checkOutput("seedB_nonce", 64'(word), 64'(expNonce));
      checkOutput("seedB_hashled", 64'(hashLed12), 64'd1);

      repeat (20) @(negedge clk);
      checkOutput("tx_stop_bits", 64'(stopErrors), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
